// File: rtl/ld_st_wakeup_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ld_st_wakeup_queue
//  Purpose  : In-order load/store issue queue sitting between dispatch/rename
//             and the address-generation / PRF-read stage. Entries wait for
//             both source tags to become ready (via NUM_CDB wakeup ports or at
//             dispatch), then issue strictly in order from the head. Branch
//             resolution clears bmask bits; a mispredict rolls the tail back
//             to the oldest entry depending on the mispredicted branch.
//  Ports    : clk, rst                     - clock, sync active-high reset
//             enq_*                        - dispatch write port (valid/ready)
//             cdb_valid, cdb_paddr         - NUM_CDB tag broadcast ports
//             br_valid, br_mispred, br_bit - branch resolution
//             flush                        - full pipeline flush
//             deq_*, prf_*                 - issue port toward AGU / PRF read
//             count                        - occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module ld_st_wakeup_queue #(
    parameter int DEPTH     = 8,
    parameter int NUM_CDB   = 2,
    parameter int PADDR_W   = 6,
    parameter int BMASK_W   = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    // dispatch
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [PADDR_W-1:0]           enq_rs1_paddr,
    input  logic [PADDR_W-1:0]           enq_rs2_paddr,
    input  logic                         enq_rs1_rdy,
    input  logic                         enq_rs2_rdy,
    input  logic [BMASK_W-1:0]           enq_bmask,
    input  logic [PAYLOAD_W-1:0]         enq_payload,
    // wakeup broadcast
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*PADDR_W-1:0]   cdb_paddr,
    // branch resolution / flush
    input  logic                         br_valid,
    input  logic                         br_mispred,
    input  logic [$clog2(BMASK_W)-1:0]   br_bit,
    input  logic                         flush,
    // issue
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [PAYLOAD_W-1:0]         deq_payload,
    output logic [BMASK_W-1:0]           deq_bmask,
    output logic [PADDR_W-1:0]           prf_rs1_paddr,
    output logic [PADDR_W-1:0]           prf_rs2_paddr,
    output logic                         prf_ren,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]   r_head_q;
    logic [c_PTR_W-1:0]   r_tail_q;
    logic [c_PTR_W-1:0]   w_head_d;
    logic [c_PTR_W-1:0]   w_tail_d;

    logic [PADDR_W-1:0]   r_rs1_paddr_q [DEPTH];
    logic [PADDR_W-1:0]   r_rs2_paddr_q [DEPTH];
    logic                 r_rs1_rdy_q   [DEPTH];
    logic                 r_rs2_rdy_q   [DEPTH];
    logic [BMASK_W-1:0]   r_bmask_q     [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload_q   [DEPTH];

    logic [PADDR_W-1:0]   w_rs1_paddr_d [DEPTH];
    logic [PADDR_W-1:0]   w_rs2_paddr_d [DEPTH];
    logic                 w_rs1_rdy_d   [DEPTH];
    logic                 w_rs2_rdy_d   [DEPTH];
    logic [BMASK_W-1:0]   w_bmask_d     [DEPTH];
    logic [PAYLOAD_W-1:0] w_payload_d   [DEPTH];

    // ------------------------------------------------------------------
    // Pointer-derived status
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]   w_head_idx;
    logic [c_IDX_W-1:0]   w_tail_idx;
    logic [c_PTR_W-1:0]   w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_mispred;
    logic                 w_resolve;
    logic                 w_enq_fire;
    logic                 w_deq_fire;
    logic                 w_head_rdy;
    logic                 w_head_squash;
    logic [BMASK_W-1:0]   w_enq_bmask;
    logic                 w_enq_rs1_rdy;
    logic                 w_enq_rs2_rdy;

    // Rollback search results
    logic                 w_rb_found;
    logic [c_PTR_W-1:0]   w_rb_ptr;
    logic [c_PTR_W-1:0]   w_scan_ptr;

    // True when any valid broadcast port carries the given tag.
    function automatic logic f_cdb_hit(
        input logic [PADDR_W-1:0]         tag,
        input logic [NUM_CDB-1:0]         vld,
        input logic [NUM_CDB*PADDR_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (vld[k] && (tags[k*PADDR_W +: PADDR_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign w_head_idx = r_head_q[c_IDX_W-1:0];
    assign w_tail_idx = r_tail_q[c_IDX_W-1:0];
    assign w_count    = r_tail_q - r_head_q;
    assign w_empty    = (r_head_q == r_tail_q);
    assign w_full     = (w_head_idx == w_tail_idx) &&
                        (r_head_q[c_IDX_W] != r_tail_q[c_IDX_W]);

    assign w_mispred  = br_valid && br_mispred;
    assign w_resolve  = br_valid && !br_mispred;

    assign enq_ready  = !w_full && !flush && !w_mispred;
    assign w_enq_fire = enq_valid && enq_ready;

    // Head readiness uses stored state only; a wakeup in this cycle is
    // only observed once it has been written into the entry.
    assign w_head_rdy    = !w_empty && r_rs1_rdy_q[w_head_idx] && r_rs2_rdy_q[w_head_idx];
    // A squashed head means the rollback point is the head itself, so the
    // issue is cancelled rather than letting a wrong-path op escape.
    assign w_head_squash = w_mispred && !w_empty && r_bmask_q[w_head_idx][br_bit];

    assign deq_valid     = w_head_rdy && !flush && !w_head_squash;
    assign w_deq_fire    = deq_valid && deq_ready;
    assign prf_ren       = w_deq_fire;

    assign deq_payload   = r_payload_q[w_head_idx];
    assign deq_bmask     = r_bmask_q[w_head_idx];
    assign prf_rs1_paddr = r_rs1_paddr_q[w_head_idx];
    assign prf_rs2_paddr = r_rs2_paddr_q[w_head_idx];
    assign count         = w_count;

    // Incoming entry: resolve clear and wakeup bypass apply at write time so
    // a broadcast coinciding with dispatch is not lost.
    always_comb begin
        w_enq_bmask = enq_bmask;
        if (w_resolve) begin
            w_enq_bmask[br_bit] = 1'b0;
        end
        w_enq_rs1_rdy = enq_rs1_rdy || f_cdb_hit(enq_rs1_paddr, cdb_valid, cdb_paddr);
        w_enq_rs2_rdy = enq_rs2_rdy || f_cdb_hit(enq_rs2_paddr, cdb_valid, cdb_paddr);
    end

    // ------------------------------------------------------------------
    // Rollback point: oldest occupied entry (from head) depending on the
    // mispredicted branch. Scanning youngest-to-oldest lets the oldest hit
    // overwrite younger ones. Pointer arithmetic keeps the wrap bit right.
    // ------------------------------------------------------------------
    always_comb begin
        w_rb_found = 1'b0;
        w_rb_ptr   = r_tail_q;
        w_scan_ptr = r_head_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_scan_ptr = r_head_q + c_PTR_W'(i);
            if ((c_PTR_W'(i) < w_count) &&
                r_bmask_q[w_scan_ptr[c_IDX_W-1:0]][br_bit]) begin
                w_rb_found = 1'b1;
                w_rb_ptr   = w_scan_ptr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer next-state: flush > rollback > enqueue on tail,
    // flush > dequeue on head.
    // ------------------------------------------------------------------
    always_comb begin
        w_head_d = r_head_q;
        w_tail_d = r_tail_q;
        if (flush) begin
            w_head_d = '0;
            w_tail_d = '0;
        end else begin
            if (w_deq_fire) begin
                w_head_d = r_head_q + c_PTR_W'(1);
            end
            if (w_mispred && w_rb_found) begin
                w_tail_d = w_rb_ptr;
            end else if (w_enq_fire) begin
                w_tail_d = r_tail_q + c_PTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry next-state: wakeup, bmask clear, enqueue write.
    // Wakeup is applied to every slot; slots outside head..tail are dead
    // and get fully overwritten on their next enqueue.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rs1_paddr_d[i] = r_rs1_paddr_q[i];
            w_rs2_paddr_d[i] = r_rs2_paddr_q[i];
            w_payload_d[i]   = r_payload_q[i];
            w_rs1_rdy_d[i]   = r_rs1_rdy_q[i] || f_cdb_hit(r_rs1_paddr_q[i], cdb_valid, cdb_paddr);
            w_rs2_rdy_d[i]   = r_rs2_rdy_q[i] || f_cdb_hit(r_rs2_paddr_q[i], cdb_valid, cdb_paddr);
            w_bmask_d[i]     = r_bmask_q[i];
            if (w_resolve) begin
                w_bmask_d[i][br_bit] = 1'b0;
            end
            if (w_enq_fire && (w_tail_idx == c_IDX_W'(i))) begin
                w_rs1_paddr_d[i] = enq_rs1_paddr;
                w_rs2_paddr_d[i] = enq_rs2_paddr;
                w_payload_d[i]   = enq_payload;
                w_rs1_rdy_d[i]   = w_enq_rs1_rdy;
                w_rs2_rdy_d[i]   = w_enq_rs2_rdy;
                w_bmask_d[i]     = w_enq_bmask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q <= '0;
            r_tail_q <= '0;
        end else begin
            r_head_q <= w_head_d;
            r_tail_q <= w_tail_d;
        end
    end

    // Entry contents need no reset: occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_rs1_paddr_q[i] <= w_rs1_paddr_d[i];
            r_rs2_paddr_q[i] <= w_rs2_paddr_d[i];
            r_rs1_rdy_q[i]   <= w_rs1_rdy_d[i];
            r_rs2_rdy_q[i]   <= w_rs2_rdy_d[i];
            r_bmask_q[i]     <= w_bmask_d[i];
            r_payload_q[i]   <= w_payload_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ld_st_wakeup_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ld_st_wakeup_queue
//  Purpose  : Directed, table-driven self-checking bench for
//             ld_st_wakeup_queue. Each row gives the inputs for one cycle and
//             the outputs expected in that cycle (before the clock edge).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ld_st_wakeup_queue;

    logic        clk;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [5:0]  enq_rs1_paddr;
    logic [5:0]  enq_rs2_paddr;
    logic        enq_rs1_rdy;
    logic        enq_rs2_rdy;
    logic [3:0]  enq_bmask;
    logic [63:0] enq_payload;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_paddr;
    logic        br_valid;
    logic        br_mispred;
    logic [1:0]  br_bit;
    logic        flush;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_payload;
    logic [3:0]  deq_bmask;
    logic [5:0]  prf_rs1_paddr;
    logic [5:0]  prf_rs2_paddr;
    logic        prf_ren;
    logic [3:0]  count;

    int n_chk = 0;
    int n_err = 0;

    ld_st_wakeup_queue #(
        .DEPTH(8), .NUM_CDB(2), .PADDR_W(6), .BMASK_W(4), .PAYLOAD_W(64)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_rs1_paddr(enq_rs1_paddr), .enq_rs2_paddr(enq_rs2_paddr),
        .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
        .enq_bmask(enq_bmask), .enq_payload(enq_payload),
        .cdb_valid(cdb_valid), .cdb_paddr(cdb_paddr),
        .br_valid(br_valid), .br_mispred(br_mispred), .br_bit(br_bit),
        .flush(flush),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_payload(deq_payload), .deq_bmask(deq_bmask),
        .prf_rs1_paddr(prf_rs1_paddr), .prf_rs2_paddr(prf_rs2_paddr),
        .prf_ren(prf_ren), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [5:0]  rs1;
        logic        r1;
        logic [5:0]  rs2;
        logic        r2;
        logic [3:0]  bm;
        logic [63:0] pl;
        logic [1:0]  cv;
        logic [11:0] cp;
        logic        bv;
        logic        bmis;
        logic [1:0]  bb;
        logic        fl;
        logic        dr;
        logic        xer;
        logic        xdv;
        logic        xpr;
        logic [3:0]  xcnt;
        logic [63:0] xpl;
        logic [3:0]  xbm;
        logic [5:0]  xrs1;
    } vec_t;

    vec_t tv[$];

    // Column order: inputs (ev,rs1,r1,rs2,r2,bm,pl,cv,cp,bv,bmis,bb,fl,dr)
    // then expected (enq_ready,deq_valid,prf_ren,count,payload,bmask,rs1).
    // Head payload/bmask/rs1 are only compared when deq_valid is expected.
    function automatic vec_t mkv(
        input logic ev, input logic [5:0] rs1, input logic r1,
        input logic [5:0] rs2, input logic r2, input logic [3:0] bm,
        input int pl, input logic [1:0] cv, input logic [11:0] cp,
        input logic bv, input logic bmis, input logic [1:0] bb,
        input logic fl, input logic dr,
        input logic xer, input logic xdv, input logic xpr, input int xcnt,
        input int xpl, input logic [3:0] xbm, input logic [5:0] xrs1);
        vec_t v;
        v.ev = ev; v.rs1 = rs1; v.r1 = r1; v.rs2 = rs2; v.r2 = r2;
        v.bm = bm; v.pl = 64'(pl); v.cv = cv; v.cp = cp;
        v.bv = bv; v.bmis = bmis; v.bb = bb; v.fl = fl; v.dr = dr;
        v.xer = xer; v.xdv = xdv; v.xpr = xpr; v.xcnt = 4'(xcnt);
        v.xpl = 64'(xpl); v.xbm = xbm; v.xrs1 = xrs1;
        return v;
    endfunction

    // Idle-input row with the given deq_ready and expectations.
    function automatic vec_t idl(input logic dr, input logic xer, input logic xdv,
                                 input logic xpr, input int xcnt, input int xpl,
                                 input logic [3:0] xbm, input logic [5:0] xrs1);
        return mkv(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, dr,
                   xer, xdv, xpr, xcnt, xpl, xbm, xrs1);
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, row, act, exp);
        end
    endtask

    task automatic set_idle();
        enq_valid = 0; enq_rs1_paddr = 0; enq_rs2_paddr = 0;
        enq_rs1_rdy = 1; enq_rs2_rdy = 1; enq_bmask = 0; enq_payload = 0;
        cdb_valid = 0; cdb_paddr = 0; br_valid = 0; br_mispred = 0;
        br_bit = 0; flush = 0; deq_ready = 0;
    endtask

    task automatic drive(input vec_t v);
        enq_valid = v.ev; enq_rs1_paddr = v.rs1; enq_rs1_rdy = v.r1;
        enq_rs2_paddr = v.rs2; enq_rs2_rdy = v.r2; enq_bmask = v.bm;
        enq_payload = v.pl; cdb_valid = v.cv; cdb_paddr = v.cp;
        br_valid = v.bv; br_mispred = v.bmis; br_bit = v.bb;
        flush = v.fl; deq_ready = v.dr;
    endtask

    task automatic check_idle_state(input string nm);
        chk({nm, "_count"},     -1, 64'(count),     64'd0);
        chk({nm, "_deq_valid"}, -1, 64'(deq_valid), 64'd0);
        chk({nm, "_enq_ready"}, -1, 64'(enq_ready), 64'd1);
        chk({nm, "_prf_ren"},   -1, 64'(prf_ren),   64'd0);
    endtask

    logic [3:0] bm_s4 [5];
    logic [3:0] bm_s6 [4];
    logic [3:0] bm_s5 [5];
    logic [3:0] bm_s5_after [6];

    initial begin
        bm_s4 = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2};
        bm_s6 = '{4'h0, 4'h0, 4'h2, 4'h2};
        bm_s5 = '{4'h3, 4'h0, 4'h3, 4'h2, 4'h2};
        bm_s5_after = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h4};

        // --- fill 8 ready entries, full, then drain in order ---
        for (int i = 0; i < 8; i++)
            tv.push_back(mkv(1, 0, 1, 0, 1, 0, i + 1, 0, 0, 0, 0, 0, 0, 0,
                             1, (i > 0), 0, i, 1, 0, 0));
        // full: enqueue refused even though a dequeue fires this cycle
        tv.push_back(mkv(1, 0, 1, 0, 1, 0, 99, 0, 0, 0, 0, 0, 0, 1,
                         0, 1, 1, 8, 1, 0, 0));
        for (int i = 0; i < 7; i++)
            tv.push_back(idl(1, 1, 1, 1, 7 - i, i + 2, 0, 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));

        // --- wakeup via CDB port 1, visible one cycle later ---
        tv.push_back(mkv(1, 5, 0, 0, 1, 0, 10, 0, 0, 0, 0, 0, 0, 1,
                         1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(0, 0, 1, 0, 1, 0, 0, 2'b10, 12'h140, 0, 0, 0, 0, 1,
                         1, 0, 0, 1, 0, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 1, 10, 0, 5));
        // --- enqueue bypass: CDB port 0 tag 5 in the fire cycle ---
        tv.push_back(mkv(1, 5, 0, 0, 1, 0, 11, 2'b01, 12'h005, 0, 0, 0, 0, 1,
                         1, 0, 0, 0, 0, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 1, 11, 0, 5));

        // --- non-ready head blocks ready younger entry ---
        tv.push_back(mkv(1, 0, 1, 7, 0, 0, 20, 0, 0, 0, 0, 0, 0, 1,
                         1, 0, 0, 0, 0, 0, 0));
        // non-matching tags 6 and 8 on both ports
        tv.push_back(mkv(1, 0, 1, 0, 1, 0, 21, 2'b11, 12'h206, 0, 0, 0, 0, 1,
                         1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mkv(0, 0, 1, 0, 1, 0, 0, 2'b01, 12'h007, 0, 0, 0, 0, 1,
                         1, 0, 0, 2, 0, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 2, 20, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 1, 21, 0, 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));

        // --- mispredict br_bit=1 on 0,0,2,2,2 fill (crosses index 7->0) ---
        for (int i = 0; i < 5; i++)
            tv.push_back(mkv(1, 0, 1, 0, 1, bm_s4[i], 30 + i, 0, 0, 0, 0, 0, 0, 0,
                             1, (i > 0), 0, i, 30, 0, 0));
        tv.push_back(mkv(1, 0, 1, 0, 1, 0, 35, 0, 0, 1, 1, 1, 0, 0,
                         0, 1, 0, 5, 30, 0, 0));
        tv.push_back(idl(0, 1, 1, 0, 2, 30, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 2, 30, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 1, 31, 0, 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));

        // --- wrap: start at index 6, squash from the wrapped entry ---
        for (int i = 0; i < 4; i++)
            tv.push_back(mkv(1, 0, 1, 0, 1, bm_s6[i], 40 + i, 0, 0, 0, 0, 0, 0, 0,
                             1, (i > 0), 0, i, 40, 0, 0));
        tv.push_back(mkv(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0,
                         0, 1, 0, 4, 40, 0, 0));
        tv.push_back(idl(0, 1, 1, 0, 2, 40, 0, 0));
        tv.push_back(mkv(1, 0, 1, 0, 1, 0, 44, 0, 0, 0, 0, 0, 0, 0,
                         1, 1, 0, 2, 40, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 3, 40, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 2, 41, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 1, 44, 0, 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));

        // --- correct resolve br_bit=1, incl. incoming entry, then no-match mispredict ---
        for (int i = 0; i < 5; i++)
            tv.push_back(mkv(1, 0, 1, 0, 1, bm_s5[i], 50 + i, 0, 0, 0, 0, 0, 0, 0,
                             1, (i > 0), 0, i, 50, 3, 0));
        tv.push_back(mkv(1, 0, 1, 0, 1, 4'h6, 55, 0, 0, 1, 0, 1, 0, 0,
                         1, 1, 0, 5, 50, 3, 0));
        tv.push_back(mkv(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0,
                         0, 1, 0, 6, 50, 1, 0));
        tv.push_back(idl(0, 1, 1, 0, 6, 50, 1, 0));
        for (int i = 0; i < 6; i++)
            tv.push_back(idl(1, 1, 1, 1, 6 - i, 50 + i, bm_s5_after[i], 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));

        // --- mispredict squashing the head: issue suppressed ---
        tv.push_back(mkv(1, 0, 1, 0, 1, 4'h4, 60, 0, 0, 0, 0, 0, 0, 0,
                         1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 1,
                         0, 0, 0, 1, 0, 0, 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));
        // --- mispredict with unsquashed head dequeuing the same cycle ---
        tv.push_back(mkv(1, 0, 1, 0, 1, 4'h0, 61, 0, 0, 0, 0, 0, 0, 0,
                         1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(1, 0, 1, 0, 1, 4'h4, 62, 0, 0, 0, 0, 0, 0, 0,
                         1, 1, 0, 1, 61, 0, 0));
        tv.push_back(mkv(1, 0, 1, 0, 1, 4'h4, 63, 0, 0, 0, 0, 0, 0, 0,
                         1, 1, 0, 2, 61, 0, 0));
        tv.push_back(mkv(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 1,
                         0, 1, 1, 3, 61, 0, 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));

        // --- flush during simultaneous enqueue + dequeue ---
        tv.push_back(mkv(1, 0, 1, 0, 1, 0, 70, 0, 0, 0, 0, 0, 0, 0,
                         1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(1, 0, 1, 0, 1, 0, 71, 0, 0, 0, 0, 0, 0, 0,
                         1, 1, 0, 1, 70, 0, 0));
        tv.push_back(mkv(1, 0, 1, 0, 1, 0, 72, 0, 0, 0, 0, 0, 1, 1,
                         0, 0, 0, 2, 0, 0, 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(1, 0, 1, 0, 1, 0, 73, 0, 0, 0, 0, 0, 0, 0,
                         1, 0, 0, 0, 0, 0, 0));
        tv.push_back(idl(1, 1, 1, 1, 1, 73, 0, 0));
        tv.push_back(idl(1, 1, 0, 0, 0, 0, 0, 0));

        // ---------------- reset ----------------
        set_idle();
        rst = 1'b1;
        enq_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        check_idle_state("reset");
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        foreach (tv[r]) begin
            drive(tv[r]);
            @(negedge clk);
            chk("enq_ready", r, 64'(enq_ready), 64'(tv[r].xer));
            chk("deq_valid", r, 64'(deq_valid), 64'(tv[r].xdv));
            chk("prf_ren",   r, 64'(prf_ren),   64'(tv[r].xpr));
            chk("count",     r, 64'(count),     64'(tv[r].xcnt));
            if (tv[r].xdv) begin
                chk("deq_payload",   r, deq_payload,         tv[r].xpl);
                chk("deq_bmask",     r, 64'(deq_bmask),      64'(tv[r].xbm));
                chk("prf_rs1_paddr", r, 64'(prf_rs1_paddr),  64'(tv[r].xrs1));
            end
            @(posedge clk);
            #1;
        end

        // ---------------- reset from a non-empty queue ----------------
        set_idle();
        enq_valid = 1'b1;
        enq_payload = 64'd80;
        repeat (2) @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
        chk("pre_reset_count", -1, 64'(count), 64'd2);
        rst = 1'b1;
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        check_idle_state("midrun_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
